// File: rtl/mem_req_queue_if.sv
// Bundle of the upstream (cache/arbiter) and downstream (memory) request and
// write-data channels carried through mem_req_queue.
interface mem_req_queue_if #(
  parameter int ADDR_BITS = 28,
  parameter int TAG_BITS  = 5,
  parameter int DATA_BITS = 128
);
  localparam int MASK_BITS = DATA_BITS / 8;

  logic                 up_req_valid;
  logic                 up_req_ready;
  logic                 up_req_rw;
  logic [ADDR_BITS-1:0] up_req_addr;
  logic [TAG_BITS-1:0]  up_req_tag;
  logic                 up_data_valid;
  logic                 up_data_ready;
  logic [DATA_BITS-1:0] up_data_bits;
  logic [MASK_BITS-1:0] up_data_mask;
  logic                 dn_req_valid;
  logic                 dn_req_ready;
  logic                 dn_req_rw;
  logic [ADDR_BITS-1:0] dn_req_addr;
  logic [TAG_BITS-1:0]  dn_req_tag;
  logic                 dn_data_valid;
  logic                 dn_data_ready;
  logic [DATA_BITS-1:0] dn_data_bits;
  logic [MASK_BITS-1:0] dn_data_mask;
  logic                 idle;

  // The queue itself.
  modport slave (
    input  up_req_valid, up_req_rw, up_req_addr, up_req_tag,
    input  up_data_valid, up_data_bits, up_data_mask,
    input  dn_req_ready, dn_data_ready,
    output up_req_ready, up_data_ready,
    output dn_req_valid, dn_req_rw, dn_req_addr, dn_req_tag,
    output dn_data_valid, dn_data_bits, dn_data_mask,
    output idle
  );

  // The surrounding system: feeds the upstream side, sinks the downstream side.
  modport master (
    output up_req_valid, up_req_rw, up_req_addr, up_req_tag,
    output up_data_valid, up_data_bits, up_data_mask,
    output dn_req_ready, dn_data_ready,
    input  up_req_ready, up_data_ready,
    input  dn_req_valid, dn_req_rw, dn_req_addr, dn_req_tag,
    input  dn_data_valid, dn_data_bits, dn_data_mask,
    input  idle
  );
endinterface

// File: rtl/mem_req_queue.sv
// Decoupling queue between the cache memory port and main memory: a command FIFO
// and a write-data FIFO, with writes released only once all their beats are held.
module mem_req_queue #(
  parameter int ADDR_BITS  = 28,
  parameter int TAG_BITS   = 5,
  parameter int DATA_BITS  = 128,
  parameter int DATA_BEATS = 4,
  parameter int CMD_DEPTH  = 4,
  parameter int DATA_DEPTH = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  mem_req_queue_if.slave bus
);
  localparam int MASK_BITS = DATA_BITS / 8;
  localparam int CPW       = $clog2(CMD_DEPTH);
  localparam int CCW       = CPW + 1;
  localparam int DPW       = $clog2(DATA_DEPTH);
  localparam int DCW       = DPW + 1;

  // Storage is never reset; only pointers and counters are.
  logic                 r_cmd_rw   [CMD_DEPTH];
  logic [ADDR_BITS-1:0] r_cmd_addr [CMD_DEPTH];
  logic [TAG_BITS-1:0]  r_cmd_tag  [CMD_DEPTH];
  logic [DATA_BITS-1:0] r_dat_bits [DATA_DEPTH];
  logic [MASK_BITS-1:0] r_dat_mask [DATA_DEPTH];

  logic [CPW-1:0] r_cmd_wp, r_cmd_rp;
  logic [CCW-1:0] r_cmd_cnt;
  logic [DPW-1:0] r_dat_wp, r_dat_rp;
  logic [DCW-1:0] r_dat_cnt;
  logic [DCW-1:0] r_claimed;

  logic           w_cmd_push, w_cmd_pop;
  logic           w_dat_push, w_dat_pop;
  logic           w_wr_issue;
  logic           w_head_rw;
  logic [DCW-1:0] w_unclaimed;
  logic [DCW-1:0] w_claim_add;
  logic [DCW-1:0] w_claim_sub;

  assign w_head_rw   = r_cmd_rw[r_cmd_rp];
  assign w_unclaimed = r_dat_cnt - r_claimed;

  // Ready/valid come from registered state only, so no combinational path
  // exists from any input handshake signal to any output handshake signal.
  assign bus.up_req_ready  = (r_cmd_cnt < CCW'(CMD_DEPTH));
  assign bus.up_data_ready = (r_dat_cnt < DCW'(DATA_DEPTH));
  assign bus.dn_req_valid  = (r_cmd_cnt != '0) &&
                             (!w_head_rw || (w_unclaimed >= DCW'(DATA_BEATS)));
  assign bus.dn_data_valid = (r_claimed != '0);
  assign bus.idle          = (r_cmd_cnt == '0) && (r_dat_cnt == '0) && (r_claimed == '0);

  assign bus.dn_req_rw    = w_head_rw;
  assign bus.dn_req_addr  = r_cmd_addr[r_cmd_rp];
  assign bus.dn_req_tag   = r_cmd_tag[r_cmd_rp];
  assign bus.dn_data_bits = r_dat_bits[r_dat_rp];
  assign bus.dn_data_mask = r_dat_mask[r_dat_rp];

  assign w_cmd_push = bus.up_req_valid  && bus.up_req_ready;
  assign w_cmd_pop  = bus.dn_req_valid  && bus.dn_req_ready;
  assign w_dat_push = bus.up_data_valid && bus.up_data_ready;
  assign w_dat_pop  = bus.dn_data_valid && bus.dn_data_ready;
  assign w_wr_issue = w_cmd_pop && w_head_rw;

  assign w_claim_add = w_wr_issue ? DCW'(DATA_BEATS) : '0;
  assign w_claim_sub = DCW'(w_dat_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd_wp  <= '0;
      r_cmd_rp  <= '0;
      r_cmd_cnt <= '0;
      r_dat_wp  <= '0;
      r_dat_rp  <= '0;
      r_dat_cnt <= '0;
      r_claimed <= '0;
    end else begin
      if (w_cmd_push) r_cmd_wp <= r_cmd_wp + CPW'(1);
      if (w_cmd_pop)  r_cmd_rp <= r_cmd_rp + CPW'(1);
      if (w_dat_push) r_dat_wp <= r_dat_wp + DPW'(1);
      if (w_dat_pop)  r_dat_rp <= r_dat_rp + DPW'(1);

      case ({w_cmd_push, w_cmd_pop})
        2'b10:   r_cmd_cnt <= r_cmd_cnt + CCW'(1);
        2'b01:   r_cmd_cnt <= r_cmd_cnt - CCW'(1);
        default: r_cmd_cnt <= r_cmd_cnt;
      endcase

      case ({w_dat_push, w_dat_pop})
        2'b10:   r_dat_cnt <= r_dat_cnt + DCW'(1);
        2'b01:   r_dat_cnt <= r_dat_cnt - DCW'(1);
        default: r_dat_cnt <= r_dat_cnt;
      endcase

      // Issuing a write claims a full line; a beat leaving in the same cycle
      // nets out to DATA_BEATS-1.
      r_claimed <= r_claimed + w_claim_add - w_claim_sub;
    end
  end

  always_ff @(posedge clk) begin
    if (w_cmd_push) begin
      r_cmd_rw[r_cmd_wp]   <= bus.up_req_rw;
      r_cmd_addr[r_cmd_wp] <= bus.up_req_addr;
      r_cmd_tag[r_cmd_wp]  <= bus.up_req_tag;
    end
    if (w_dat_push) begin
      r_dat_bits[r_dat_wp] <= bus.up_data_bits;
      r_dat_mask[r_dat_wp] <= bus.up_data_mask;
    end
  end

  // A data FIFO smaller than one line could never release a write.
  a_depth_ok: assert property (@(posedge clk) DATA_DEPTH >= DATA_BEATS);
  a_pow2: assert property (@(posedge clk)
    ((CMD_DEPTH & (CMD_DEPTH - 1)) == 0) && ((DATA_DEPTH & (DATA_DEPTH - 1)) == 0));
  // Surplus beats for a write would leave claimed beats outrunning held beats.
  a_claim_le_held: assert property (@(posedge clk) disable iff (!reset_n)
    r_claimed <= r_dat_cnt);
endmodule

// File: tb/tb_mem_req_queue.sv
// Directed bench for mem_req_queue: reads, writes with late/early beats,
// write-before-read ordering, command backpressure and mid-burst reset.
module tb_mem_req_queue;
  localparam int ADDR_BITS  = 28;
  localparam int TAG_BITS   = 5;
  localparam int DATA_BITS  = 128;
  localparam int DATA_BEATS = 4;
  localparam int CMD_DEPTH  = 4;
  localparam int DATA_DEPTH = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mem_req_queue_if #(.ADDR_BITS(ADDR_BITS), .TAG_BITS(TAG_BITS), .DATA_BITS(DATA_BITS)) bus ();

  mem_req_queue #(
    .ADDR_BITS(ADDR_BITS), .TAG_BITS(TAG_BITS), .DATA_BITS(DATA_BITS),
    .DATA_BEATS(DATA_BEATS), .CMD_DEPTH(CMD_DEPTH), .DATA_DEPTH(DATA_DEPTH)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_BITS-1:0] beat(input int id, input int b);
    return {32'(id), 32'(b), 32'h1234_5678, 32'(id * 16 + b)};
  endfunction

  function automatic logic [DATA_BITS/8-1:0] bmask(input int id, input int b);
    return {8'(id), 8'(b + 1)};
  endfunction

  task automatic set_req(input logic v, input logic rw, input int addr, input int tag);
    bus.up_req_valid = v;
    bus.up_req_rw    = rw;
    bus.up_req_addr  = ADDR_BITS'(addr);
    bus.up_req_tag   = TAG_BITS'(tag);
  endtask

  task automatic set_beat(input logic v, input int id, input int b);
    bus.up_data_valid = v;
    bus.up_data_bits  = beat(id, b);
    bus.up_data_mask  = bmask(id, b);
  endtask

  initial begin
    int iss;
    int nb;
    logic [TAG_BITS-1:0] exp_tag;

    set_req(1'b0, 1'b0, 0, 0);
    set_beat(1'b0, 0, 0);
    bus.dn_req_ready  = 1'b0;
    bus.dn_data_ready = 1'b0;

    // Reset state
    #1;
    chk("rst_dn_req_valid", bus.dn_req_valid, 1'b0);
    chk("rst_dn_data_valid", bus.dn_data_valid, 1'b0);
    chk("rst_up_req_ready", bus.up_req_ready, 1'b1);
    chk("rst_up_data_ready", bus.up_data_ready, 1'b1);
    chk("rst_idle", bus.idle, 1'b1);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // 1: single read passes through with one cycle of latency
    set_req(1'b1, 1'b0, 'h123, 3);
    bus.dn_req_ready = 1'b1;
    chk("t1_valid_before_push", bus.dn_req_valid, 1'b0);
    tick();
    set_req(1'b0, 1'b0, 0, 0);
    chk("t1_dn_req_valid", bus.dn_req_valid, 1'b1);
    chk("t1_dn_req_rw", bus.dn_req_rw, 1'b0);
    chk("t1_dn_req_addr", bus.dn_req_addr, 'h123);
    chk("t1_dn_req_tag", bus.dn_req_tag, 3);
    chk("t1_idle_busy", bus.idle, 1'b0);
    tick();
    chk("t1_dn_req_valid_after", bus.dn_req_valid, 1'b0);
    chk("t1_idle_after", bus.idle, 1'b1);

    // 2: write command first, its beats arrive later
    bus.dn_data_ready = 1'b1;
    set_req(1'b1, 1'b1, 'h200, 5);
    tick();
    set_req(1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t2_wait_req_valid", bus.dn_req_valid, 1'b0);
      chk("t2_wait_data_valid", bus.dn_data_valid, 1'b0);
      tick();
    end
    for (int b = 0; b < DATA_BEATS; b++) begin
      set_beat(1'b1, 'hA, b);
      chk("t2_beat_req_valid", bus.dn_req_valid, 1'b0);
      chk("t2_beat_data_valid", bus.dn_data_valid, 1'b0);
      tick();
    end
    set_beat(1'b0, 0, 0);
    chk("t2_req_valid", bus.dn_req_valid, 1'b1);
    chk("t2_req_rw", bus.dn_req_rw, 1'b1);
    chk("t2_req_addr", bus.dn_req_addr, 'h200);
    chk("t2_req_tag", bus.dn_req_tag, 5);
    chk("t2_no_data_before_issue", bus.dn_data_valid, 1'b0);
    tick();
    chk("t2_req_valid_after_issue", bus.dn_req_valid, 1'b0);
    for (int b = 0; b < DATA_BEATS; b++) begin
      chk("t2_data_valid", bus.dn_data_valid, 1'b1);
      chk("t2_data_bits", bus.dn_data_bits, beat('hA, b));
      chk("t2_data_mask", bus.dn_data_mask, bmask('hA, b));
      tick();
    end
    chk("t2_data_valid_end", bus.dn_data_valid, 1'b0);
    chk("t2_idle", bus.idle, 1'b1);

    // 3: two lines of beats first, then both write commands
    for (int b = 0; b < 2 * DATA_BEATS; b++) begin
      set_beat(1'b1, 'hB, b);
      chk("t3_up_data_ready", bus.up_data_ready, 1'b1);
      tick();
    end
    set_beat(1'b0, 0, 0);
    chk("t3_up_data_ready_full", bus.up_data_ready, 1'b0);
    chk("t3_no_data_unclaimed", bus.dn_data_valid, 1'b0);
    iss = 0;
    nb  = 0;
    for (int c = 0; c < 16; c++) begin
      if (c == 0)      set_req(1'b1, 1'b1, 'h300, 6);
      else if (c == 1) set_req(1'b1, 1'b1, 'h340, 7);
      else             set_req(1'b0, 1'b0, 0, 0);
      if (bus.dn_req_valid) begin
        exp_tag = (iss == 0) ? TAG_BITS'(6) : TAG_BITS'(7);
        chk("t3_issue_tag", bus.dn_req_tag, exp_tag);
        iss++;
      end
      if (bus.dn_data_valid) begin
        chk("t3_drain_bits", bus.dn_data_bits, beat('hB, nb));
        nb++;
      end
      tick();
    end
    chk("t3_issues", iss, 2);
    chk("t3_beats", nb, 2 * DATA_BEATS);
    chk("t3_idle", bus.idle, 1'b1);

    // 4: a read queued behind a data-less write waits for the write
    set_req(1'b1, 1'b1, 'h400, 8);
    tick();
    set_req(1'b1, 1'b0, 'h500, 9);
    tick();
    set_req(1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("t4_read_blocked", bus.dn_req_valid, 1'b0);
      tick();
    end
    for (int b = 0; b < DATA_BEATS; b++) begin
      set_beat(1'b1, 'hC, b);
      chk("t4_blocked_during_beats", bus.dn_req_valid, 1'b0);
      tick();
    end
    set_beat(1'b0, 0, 0);
    chk("t4_w_valid", bus.dn_req_valid, 1'b1);
    chk("t4_w_rw", bus.dn_req_rw, 1'b1);
    chk("t4_w_tag", bus.dn_req_tag, 8);
    tick();
    chk("t4_r_valid", bus.dn_req_valid, 1'b1);
    chk("t4_r_rw", bus.dn_req_rw, 1'b0);
    chk("t4_r_tag", bus.dn_req_tag, 9);
    chk("t4_r_addr", bus.dn_req_addr, 'h500);
    chk("t4_data0", bus.dn_data_bits, beat('hC, 0));
    tick();
    for (int b = 1; b < DATA_BEATS; b++) begin
      chk("t4_data_valid", bus.dn_data_valid, 1'b1);
      chk("t4_data_bits", bus.dn_data_bits, beat('hC, b));
      tick();
    end
    chk("t4_idle", bus.idle, 1'b1);

    // 5: command FIFO fills under backpressure, then drains one per cycle
    bus.dn_req_ready = 1'b0;
    for (int i = 0; i < CMD_DEPTH; i++) begin
      set_req(1'b1, 1'b0, 'h600 + i, 10 + i);
      chk("t5_ready_filling", bus.up_req_ready, 1'b1);
      tick();
    end
    set_req(1'b0, 1'b0, 0, 0);
    chk("t5_ready_full", bus.up_req_ready, 1'b0);
    chk("t5_head_tag", bus.dn_req_tag, 10);
    bus.dn_req_ready = 1'b1;
    #1;
    chk("t5_ready_still_full", bus.up_req_ready, 1'b0);
    tick();
    chk("t5_ready_after_pop", bus.up_req_ready, 1'b1);
    for (int i = 1; i < CMD_DEPTH; i++) begin
      chk("t5_pop_valid", bus.dn_req_valid, 1'b1);
      chk("t5_pop_tag", bus.dn_req_tag, 10 + i);
      tick();
    end
    chk("t5_empty", bus.dn_req_valid, 1'b0);
    chk("t5_idle", bus.idle, 1'b1);

    // 6: reset in the middle of a write burst
    bus.dn_req_ready = 1'b0;
    for (int b = 0; b < DATA_BEATS; b++) begin
      set_beat(1'b1, 'hD, b);
      tick();
    end
    set_beat(1'b0, 0, 0);
    set_req(1'b1, 1'b1, 'h700, 14);
    bus.dn_req_ready  = 1'b1;
    bus.dn_data_ready = 1'b1;
    tick();
    set_req(1'b0, 1'b0, 0, 0);
    chk("t6_w_valid", bus.dn_req_valid, 1'b1);
    tick();
    chk("t6_d0", bus.dn_data_bits, beat('hD, 0));
    tick();
    chk("t6_d1", bus.dn_data_bits, beat('hD, 1));
    tick();
    chk("t6_d2_valid", bus.dn_data_valid, 1'b1);
    chk("t6_d2", bus.dn_data_bits, beat('hD, 2));
    bus.dn_data_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_dn_data_valid", bus.dn_data_valid, 1'b0);
    chk("t6_rst_dn_req_valid", bus.dn_req_valid, 1'b0);
    chk("t6_rst_up_req_ready", bus.up_req_ready, 1'b1);
    chk("t6_rst_up_data_ready", bus.up_data_ready, 1'b1);
    chk("t6_rst_idle", bus.idle, 1'b1);
    tick();
    reset_n = 1'b1;
    tick();
    chk("t6_post_rst_idle", bus.idle, 1'b1);
    chk("t6_post_rst_data_valid", bus.dn_data_valid, 1'b0);
    set_req(1'b1, 1'b0, 'h777, 15);
    tick();
    set_req(1'b0, 1'b0, 0, 0);
    chk("t6_read_valid", bus.dn_req_valid, 1'b1);
    chk("t6_read_tag", bus.dn_req_tag, 15);
    chk("t6_read_addr", bus.dn_req_addr, 'h777);
    chk("t6_read_no_data", bus.dn_data_valid, 1'b0);
    tick();
    chk("t6_final_valid", bus.dn_req_valid, 1'b0);
    chk("t6_final_idle", bus.idle, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
